alu_arbiter: RTL and testbench

Shares the single-cycle combinational ALU between NUM_REQ requesters (decode stage, address generator, and similar clients) using a valid/ready handshake. Each cycle it grants at most one requester, drives the ALU with that requester's operands and opcode, and captures the result in a one-entry output register tagged with the winner's index. It sits between the requester clients and the writeback/consumer logic and is the only instantiator of the ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 42 ++++
 rtl/arb_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 81 ++++++++
 tb/tb_alu_arbiter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and widths for alu and alu_arbiter
package alu_pkg;

    localparam int ALU_W      = 32;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_MV0  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_MV1  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_MV2  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MV3  = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHRA = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHRL = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_ROR  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHL  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_ROL  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOT  = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b1011;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b1101;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b1110;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 4'b1111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle combinational ALU; B is the data operand, A the modifier
module alu
    import alu_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] ctrl,
    input  logic [ALU_W-1:0]      a,
    input  logic [ALU_W-1:0]      b,
    output logic [ALU_W-1:0]      result
);

    logic [4:0]         sh;
    logic [2*ALU_W-1:0] rol_wide;
    logic [2*ALU_W-1:0] ror_wide;

    assign sh       = a[4:0];
    assign rol_wide = {b, b} << sh;
    assign ror_wide = {b, b} >> sh;

    // Opcode decode: shifts/rotates move B by A[4:0], MVn inserts B[7:0] into byte n of A
    always_comb begin
        result = b;
        case (ctrl)
            ALU_MV0:  result = {a[31:8], b[7:0]};
            ALU_MV1:  result = {a[31:16], b[7:0], a[7:0]};
            ALU_MV2:  result = {a[31:24], b[7:0], a[15:0]};
            ALU_MV3:  result = {b[7:0], a[23:0]};
            ALU_SHRA: result = $signed(b) >>> sh;
            ALU_SHRL: result = b >> sh;
            ALU_ROR:  result = ror_wide[ALU_W-1:0];
            ALU_SHL:  result = b << sh;
            ALU_ROL:  result = rol_wide[2*ALU_W-1:ALU_W];
            ALU_NOT:  result = ~b;
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SUB:  result = b - a;
            ALU_ADD:  result = a + b;
            default:  result = b;
        endcase
    end

endmodule

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - first-set search over a request vector starting at a given index
module arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    logic found;
    int   idx;

    // Walk the requesters from start, wrapping, and take the first one that is set
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU among requesters; ALU_ARB_RR_EN selects round-robin
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ALU_W*NUM_REQ-1:0]      req_a,
    input  logic [ALU_W*NUM_REQ-1:0]      req_b,
    input  logic [ALU_CTRL_W*NUM_REQ-1:0] req_ctrl,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ALU_W-1:0]              rsp_data,
    output logic [ID_W-1:0]               rsp_id
);

    logic                  free;
    logic                  accept;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       start;
    logic [ALU_W-1:0]      alu_out;

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] last;

    // Search begins just after the most recently accepted requester
    always_comb begin
        start = (last == ID_W'(NUM_REQ - 1)) ? '0 : last + ID_W'(1);
    end

    // Pointer only advances on a real handshake, so a stalled grant keeps its turn
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last <= ID_W'(NUM_REQ - 1);
        else if (accept) last <= win;
    end
`else
    assign start = '0;
`endif

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .start  (start),
        .grant  (grant),
        .winner (win)
    );

    assign free      = !rsp_valid || rsp_ready;
    assign req_ready = (!rst && free) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    alu u_alu (
        .ctrl   (req_ctrl[ALU_CTRL_W*int'(win) +: ALU_CTRL_W]),
        .a      (req_a[ALU_W*int'(win) +: ALU_W]),
        .b      (req_b[ALU_W*int'(win) +: ALU_W]),
        .result (alu_out)
    );

    // One-entry result register: load on accept, otherwise empty on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_id    <= win;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (NUM_REQ=2)
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_data;
    logic        exp_id;
    logic        rr;

    initial begin
`ifdef ALU_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b0;
        #22;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);

        step();
        rst       = 1'b0;
        req_valid = 2'b01;
        req_a     = {32'd0, 32'd3};
        req_b     = {32'd0, 32'd5};
        req_ctrl  = {4'b0000, 4'b1110};
        #1;
        chk("single_req_ready", {30'd0, req_ready}, 32'd1);
        step();
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_rsp_data", rsp_data, 32'd8);
        chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);

        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("drain_data_kept", rsp_data, 32'd8);

        req_valid = 2'b01;
        req_a     = {32'd0, 32'd4};
        req_b     = {32'd0, 32'h8000_0001};
        req_ctrl  = {4'b0000, 4'b1000};
        #1;
        step();
        chk("rol_rsp_data", rsp_data, 32'h0000_0018);
        req_a     = {32'd0, 32'h1122_3344};
        req_b     = {32'd0, 32'h0000_00AB};
        req_ctrl  = {4'b0000, 4'b0011};
        #1;
        chk("b2b_req_ready", {30'd0, req_ready}, 32'd1);
        step();
        chk("mv3_rsp_data", rsp_data, 32'hAB22_3344);
        chk("mv3_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // Contention: req0 SUB (10-1=9), req1 XOR (F0^FF=0F); last grant so far was req 0
        req_valid = 2'b11;
        req_a     = {32'h0000_00F0, 32'd1};
        req_b     = {32'h0000_00FF, 32'd10};
        req_ctrl  = {4'b1010, 4'b1101};
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id   = rr ? ((i % 2) == 0) : 1'b0;
            exp_data = exp_id ? 32'h0000_000F : 32'd9;
            chk($sformatf("cont_ready_%0d", i), {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
            step();
            chk($sformatf("cont_id_%0d", i), {31'd0, rsp_id}, {31'd0, exp_id});
            chk($sformatf("cont_data_%0d", i), rsp_data, exp_data);
        end

        // Backpressure: result from req 0 (data 9) must be held
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_ready_%0d", i), {30'd0, req_ready}, 32'd0);
            chk($sformatf("stall_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("stall_data_%0d", i), rsp_data, 32'd9);
            chk($sformatf("stall_id_%0d", i), {31'd0, rsp_id}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        exp_id = rr ? 1'b1 : 1'b0;
        chk("release_ready", {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
        step();
        chk("nobubble_valid", {31'd0, rsp_valid}, 32'd1);
        chk("nobubble_id", {31'd0, rsp_id}, {31'd0, exp_id});
        chk("nobubble_data", rsp_data, exp_id ? 32'h0000_000F : 32'd9);

        // Async reset in the middle of a stall
        rsp_ready = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("areset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("areset_data", rsp_data, 32'd0);
        chk("areset_id", {31'd0, rsp_id}, 32'd0);
        chk("areset_ready", {30'd0, req_ready}, 32'd0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_reset_ready0", {30'd0, req_ready}, 32'd1);
        step();
        chk("post_reset_id", {31'd0, rsp_id}, 32'd0);
        chk("post_reset_data", rsp_data, 32'd9);
        chk("post_reset_ready1", {30'd0, req_ready}, rr ? 32'd2 : 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
